// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared encodings and latencies for the hazard scheduler
package hazard_stall_ctrl_pkg;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int MD_CNT_W     = 4;

  // Tuse: cycles until ID needs a source; 3 means the field is not read at all.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until a producer's result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// rtl/hazard_stall_ctrl_md_busy_timer.sv - mult/div busy countdown with reload on start
module md_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  // A start always reloads, even mid-countdown: the last start wins.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (start_i) begin
      md_cnt_d = div_i ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - Tuse/Tnew stall decision, bubble insertion and stall counter
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [1:0]       id_tuse_rs,
  input  logic [1:0]       id_tuse_rt,
  input  logic             id_is_md,
  input  logic [4:0]       ex_wa,
  input  logic [1:0]       ex_tnew,
  input  logic [4:0]       mem_wa,
  input  logic [1:0]       mem_tnew,
  input  logic             ex_md_start,
  input  logic             ex_md_div,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic data_stall_rs, data_stall_rt, md_stall, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // $zero is never a real dependency, so it cannot stall even when a producer targets it.
  assign data_stall_rs = (id_rs != 5'd0) && (id_tuse_rs != TUSE_NONE) &&
                         (((id_rs == ex_wa)  && (id_tuse_rs < ex_tnew)) ||
                          ((id_rs == mem_wa) && (id_tuse_rs < mem_tnew)));

  assign data_stall_rt = (id_rt != 5'd0) && (id_tuse_rt != TUSE_NONE) &&
                         (((id_rt == ex_wa)  && (id_tuse_rt < ex_tnew)) ||
                          ((id_rt == mem_wa) && (id_tuse_rt < mem_tnew)));

  assign md_stall = id_is_md && (md_busy || ex_md_start);
  assign stall    = data_stall_rs || data_stall_rt || md_stall;

  assign pc_en     = !stall;
  assign if_id_en  = !stall;
  assign id_ex_clr = stall;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (ex_md_start),
    .div_i   (ex_md_div),
    .busy_o  (md_busy)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic        id_is_md, ex_md_start, ex_md_div;
  logic        pc_en, if_id_en, id_ex_clr, md_busy;
  logic [31:0] stall_cnt;
  logic        pc_en4, if_id_en4, id_ex_clr4, md_busy4;
  logic [3:0]  stall_cnt4;

  typedef struct {
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          m_md = 0;
  logic [31:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_is_md(id_is_md),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_is_md(id_is_md),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_clr(id_ex_clr4),
    .md_busy(md_busy4), .stall_cnt(stall_cnt4)
  );

  function automatic logic src_hit(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 5'd0 || tuse == 2'd3) return 1'b0;
    return ((r == ex_wa) && (tuse < ex_tnew)) || ((r == mem_wa) && (tuse < mem_tnew));
  endfunction

  function automatic logic model_stall();
    return src_hit(id_rs, id_tuse_rs) || src_hit(id_rt, id_tuse_rt) ||
           (id_is_md && ((m_md != 0) || ex_md_start));
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3; id_is_md = 0;
    ex_wa = 0; ex_tnew = 0; mem_wa = 0; mem_tnew = 0; ex_md_start = 0; ex_md_div = 0;
  endtask

  // Inputs are already driven (posedge+1); expectation is pushed, compared at negedge, model advances at posedge.
  task automatic cycle(input string nm);
    exp_t e;
    e.stall = model_stall(); e.busy = (m_md != 0); e.cnt = m_cnt; e.cnt4 = m_cnt4; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (pc_en !== !e.stall || if_id_en !== !e.stall || id_ex_clr !== e.stall) begin
      miscompares++;
      $display("FAIL %s stall_outs: pc_en=%b if_id_en=%b id_ex_clr=%b required stall=%b", e.name, pc_en, if_id_en, id_ex_clr, e.stall);
    end
    vectors++;
    if (md_busy !== e.busy) begin
      miscompares++;
      $display("FAIL %s md_busy: got %b required %b", e.name, md_busy, e.busy);
    end
    vectors++;
    if (stall_cnt !== e.cnt || stall_cnt4 !== e.cnt4 || pc_en4 !== !e.stall) begin
      miscompares++;
      $display("FAIL %s stall_cnt: got %0d/%0d required %0d/%0d", e.name, stall_cnt, stall_cnt4, e.cnt, e.cnt4);
    end
    @(posedge clk);
    if (e.stall) begin
      if (m_cnt != '1) m_cnt = m_cnt + 1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    if (ex_md_start) m_md = ex_md_div ? 10 : 5;
    else if (m_md != 0) m_md = m_md - 1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_md = 0; m_cnt = '0; m_cnt4 = '0;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs();
    #2;
    vectors++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0 || pc_en !== 1'b1 || id_ex_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b cnt=%0d pc_en=%b clr=%b required 0/0/1/0", md_busy, stall_cnt, pc_en, id_ex_clr);
    end
    id_is_md = 1; ex_md_start = 1; ex_md_div = 1;
    #1;
    vectors++;
    if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_comb: pc_en=%b if_id_en=%b clr=%b required 0/0/1", pc_en, if_id_en, id_ex_clr);
    end
    @(posedge clk); #1;
    vectors++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_hold: busy=%b cnt=%0d required 0/0", md_busy, stall_cnt);
    end
    reset = 1'b1; idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_wa = 8; ex_tnew = 2; id_rs = 8; id_tuse_rs = 1;
    cycle("load_use_ex");
    ex_wa = 0; ex_tnew = 0; mem_wa = 8; mem_tnew = 1;
    cycle("load_use_mem");
    vectors++;
    if (stall_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL load_use_cnt: got %0d required 1", stall_cnt);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    id_rs = 0; id_tuse_rs = 0; ex_wa = 0; ex_tnew = 2; mem_wa = 0; mem_tnew = 1;
    cycle("zero_reg");
    id_tuse_rs = 3; id_rt = 5; id_tuse_rt = 2; ex_wa = 5; ex_tnew = 2;
    cycle("rt_forwardable");
    id_rs = 5; id_tuse_rs = 3; id_tuse_rt = 3;
    cycle("tuse_unused");
    id_rs = 5; id_tuse_rs = 0; id_rt = 5; id_tuse_rt = 1;
    cycle("both_hit");
    vectors++;
    if (stall_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL both_hit_cnt: got %0d required 1", stall_cnt);
    end
  endtask

  task automatic test_div_busy();
    do_reset();
    id_is_md = 1; ex_md_start = 1; ex_md_div = 1;
    cycle("div_start");
    ex_md_start = 0;
    for (int i = 1; i <= 11; i++) cycle($sformatf("div_T+%0d", i));
    vectors++;
    if (stall_cnt !== 32'd11 || md_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL div_total: cnt=%0d busy=%b required 11/0", stall_cnt, md_busy);
    end
  endtask

  task automatic test_mult();
    int busy_cycles = 0;
    do_reset();
    ex_md_start = 1; ex_md_div = 0;
    cycle("mult_start");
    ex_md_start = 0; id_rs = 3; id_tuse_rs = 1;
    for (int i = 0; i < 12; i++) begin
      if (md_busy === 1'b1) busy_cycles++;
      cycle("mult_nonmd");
    end
    vectors++;
    if (busy_cycles != 5 || stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL mult_window: busy_cycles=%0d cnt=%0d required 5/0", busy_cycles, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_md_start = 1; ex_md_div = 1;
    cycle("b2b_div");
    ex_md_start = 0;
    cycle("b2b_gap");
    ex_md_start = 1; ex_md_div = 0;
    cycle("b2b_mult_reload");
    ex_md_start = 0;
    for (int i = 0; i < 7; i++) cycle("b2b_drain");
  endtask

  task automatic test_async_reset();
    do_reset();
    id_is_md = 1; ex_md_start = 1; ex_md_div = 1;
    cycle("ar_start");
    ex_md_start = 0;
    for (int i = 0; i < 4; i++) cycle("ar_count");
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if (md_busy !== 1'b0 || stall_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b cnt=%0d required 0/0", md_busy, stall_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    m_md = 0; m_cnt = '0; m_cnt4 = '0;
    for (int i = 0; i < 3; i++) cycle("ar_after");
  endtask

  task automatic test_saturation();
    do_reset();
    ex_wa = 9; ex_tnew = 2; id_rt = 9; id_tuse_rt = 0;
    for (int i = 0; i < 14; i++) cycle("sat_fill");
    vectors++;
    if (stall_cnt4 !== 4'd14) begin
      miscompares++;
      $display("FAIL sat_pre: got %0d required 14", stall_cnt4);
    end
    for (int i = 0; i < 3; i++) begin
      cycle("sat_hold");
      vectors++;
      if (stall_cnt4 !== 4'd15) begin
        miscompares++;
        $display("FAIL sat_hold: got %0d required 15", stall_cnt4);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_tuse_rs = 2'($urandom_range(0, 3)); id_tuse_rt = 2'($urandom_range(0, 3));
      ex_wa = 5'($urandom_range(0, 3)); ex_tnew = 2'($urandom_range(0, 2));
      mem_wa = 5'($urandom_range(0, 3)); mem_tnew = 2'($urandom_range(0, 1));
      id_is_md = ($urandom_range(0, 3) == 0);
      ex_md_start = ($urandom_range(0, 9) == 0);
      ex_md_div = 1'($urandom_range(0, 1));
      cycle("random");
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_div_busy();
    test_mult();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
